uart_rx_param: RTL

Parametrised UART receiver, the successor to the fixed 8-bit receiver. Generalises data width, oversampling ratio, stop length and parity mode. Adds framing-error and break detection, start-bit glitch rejection, an input synchroniser and a registered data output. Sits between the pin-side rx line and the RX FIFO, clocked by the system clock and paced by the shared baud-rate s_tick generator.

---
 rtl/uart_rx_param.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled start/data/parity/stop sampling.
// It detects framing errors and line breaks, and rejects glitches on the start bit.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx           asynchronous serial line, idle high
//   s_tick       one-clk oversampling strobe, OS strobes per bit period
//   dout         last received data word (DBIT bits, received LSB first)
//   rx_done_tick one-clk pulse at frame end; dout and flags are valid from this cycle
//   parity_err   parity mismatch on the last frame
//   frame_err    stop bit sampled low on the last frame
//   break_det    last frame was a break (all zeros, stop bit low)
//   busy         high whenever the receiver is not idle
module uart_rx_param #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OS         = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            busy
);

  localparam int unsigned SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int unsigned SW   = $clog2(SMAX);
  localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          PAR_EN  = (PARITY_EN != 0);
  localparam logic          PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  state_t state, state_next;

  logic            rx_meta, rx_s;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            p, p_next;
  logic [DBIT-1:0] dout_next;
  logic            done_next, perr_next, ferr_next, brk_next;

  // End-of-frame status, evaluated from the assembled word and current line level
  logic par_exp_c, perr_c, ferr_c, brk_c;

  assign par_exp_c = (^b) ^ PAR_ODD;
  assign perr_c    = PAR_EN & (p != par_exp_c);
  assign ferr_c    = ~rx_s;
  assign brk_c     = ~rx_s & (b == '0) & (~PAR_EN | ~p);

  assign busy = (state != IDLE);

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        // A start bit that is high again at mid-bit is a glitch
        if (s_tick && (s == S_HALF)) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (s_tick && (s == S_BIT) && (n == N_LAST)) state_next = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (s_tick && (s == S_BIT)) state_next = STOP;
      end
      STOP: begin
        if (s_tick && (s == S_STOP)) state_next = brk_c ? BRK : IDLE;
      end
      BRK: begin
        // Hold off until the line returns high so a long break yields one frame
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    s_next    = s;
    n_next    = n;
    b_next    = b;
    p_next    = p;
    dout_next = dout;
    done_next = 1'b0;
    perr_next = parity_err;
    ferr_next = frame_err;
    brk_next  = break_det;
    case (state)
      IDLE: begin
        if (!rx_s) s_next = '0;
      end
      START: begin
        if (s_tick) begin
          if (s == S_HALF) begin
            if (!rx_s) begin
              s_next = '0;
              n_next = '0;
            end
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_next = '0;
            b_next = {rx_s, b[DBIT-1:1]};
            if (n != N_LAST) n_next = n + NW'(1);
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_next = '0;
            p_next = rx_s;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            dout_next = b;
            done_next = 1'b1;
            perr_next = perr_c;
            ferr_next = ferr_c;
            brk_next  = brk_c;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s            <= '0;
      n            <= '0;
      b            <= '0;
      p            <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      p            <= p_next;
      dout         <= dout_next;
      rx_done_tick <= done_next;
      parity_err   <= perr_next;
      frame_err    <= ferr_next;
      break_det    <= brk_next;
    end
  end

endmodule
